// File: rtl/sync_event_pkg.sv
// Shared types and helpers for the asynchronous event synchroniser/conditioner.
`default_nettype none

package sync_event_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        WAIT_LOW = 2'd2
    } state_e;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int num_ch, input int sync_stages,
                                     input int filter_len, input int stretch_len,
                                     input int cnt_w);
        return (num_ch >= 1) && (sync_stages >= 2) && (filter_len >= 1) &&
               (stretch_len >= 1) && (cnt_w >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_event_ch.sv
// One channel: flop-chain synchroniser, stability filter, stretch FSM and statistics.
`default_nettype none

module sync_event_ch
    import sync_event_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int STRETCH_LEN = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             async_i,
    input  logic             clr_stat_i,
    output logic             sync_level_o,
    output logic             rise_pulse_o,
    output logic             stretch_out_o,
    output logic             sticky_o,
    output logic [CNT_W-1:0] evt_cnt_o
);

    localparam int FW = clog2(FILTER_LEN + 1);
    localparam int SW = clog2(STRETCH_LEN);
    localparam logic [FW-1:0]    FILT_MAX     = FW'(FILTER_LEN);
    localparam logic [SW-1:0]    STRETCH_LOAD = SW'(STRETCH_LEN - 1);
    localparam logic [CNT_W-1:0] EVT_MAX      = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [FW-1:0]          filt_q, filt_d;
    logic                   level_q, level_d;
    logic                   rise_q;
    logic                   sticky_q, sticky_d;
    logic [CNT_W-1:0]       evt_q, evt_d;
    state_e                 state_q, state_d;
    logic [SW-1:0]          stretch_q, stretch_d;

    logic s, diff, toggle, rise;

    assign s      = sync_q[SYNC_STAGES-1];
    assign diff   = (s != level_q);
    // The level flips on the edge after the counter has seen FILTER_LEN mismatches.
    assign toggle = diff && (filt_q == FILT_MAX);
    assign rise   = toggle && !level_q;

    always_comb begin
        level_d  = level_q ^ toggle;
        filt_d   = (diff && !toggle) ? filt_q + FW'(1) : '0;
        sticky_d = sticky_q;
        evt_d    = evt_q;
        if (rise) begin
            sticky_d = 1'b1;
            evt_d    = clr_stat_i ? CNT_W'(1) :
                       (evt_q == EVT_MAX) ? evt_q : evt_q + CNT_W'(1);
        end else if (clr_stat_i) begin
            sticky_d = 1'b0;
            evt_d    = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q   <= '0;
            filt_q   <= '0;
            level_q  <= 1'b0;
            rise_q   <= 1'b0;
            sticky_q <= 1'b0;
            evt_q    <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            filt_q   <= filt_d;
            level_q  <= level_d;
            rise_q   <= rise;
            sticky_q <= sticky_d;
            evt_q    <= evt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            stretch_q <= '0;
        end else begin
            state_q   <= state_d;
            stretch_q <= stretch_d;
        end
    end

    // Decisions use the next level so stretch_out drops on the same edge as sync_level.
    always_comb begin
        state_d   = state_q;
        stretch_d = stretch_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d   = ACTIVE;
                    stretch_d = STRETCH_LOAD;
                end
            end
            ACTIVE: begin
                if (rise) begin
                    stretch_d = STRETCH_LOAD;
                end else if (stretch_q == '0) begin
                    state_d = level_d ? WAIT_LOW : IDLE;
                end else begin
                    stretch_d = stretch_q - SW'(1);
                end
            end
            WAIT_LOW: begin
                if (!level_d) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        stretch_out_o = 1'b0;
        if (state_q != IDLE) stretch_out_o = 1'b1;
    end

    assign sync_level_o = level_q;
    assign rise_pulse_o = rise_q;
    assign sticky_o     = sticky_q;
    assign evt_cnt_o    = evt_q;

endmodule

`default_nettype wire

// File: rtl/sync_event_ctrl.sv
// Multi-channel synchroniser/conditioner for asynchronous control inputs.
`default_nettype none

module sync_event_ctrl
    import sync_event_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4,
    parameter int STRETCH_LEN = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [NUM_CH-1:0]       async_in_i,
    input  logic [NUM_CH-1:0]       clr_stat_i,
    output logic [NUM_CH-1:0]       sync_level_o,
    output logic [NUM_CH-1:0]       rise_pulse_o,
    output logic [NUM_CH-1:0]       stretch_out_o,
    output logic [NUM_CH-1:0]       sticky_o,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt_o,
    output logic                    busy_o
);

    if (!params_ok(NUM_CH, SYNC_STAGES, FILTER_LEN, STRETCH_LEN, CNT_W)) begin : g_param_check
        $error("sync_event_ctrl: parameter out of range");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        sync_event_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN),
            .STRETCH_LEN (STRETCH_LEN),
            .CNT_W       (CNT_W)
        ) u_ch (
            .clk_i         (clk_i),
            .reset_i       (reset_i),
            .async_i       (async_in_i[i]),
            .clr_stat_i    (clr_stat_i[i]),
            .sync_level_o  (sync_level_o[i]),
            .rise_pulse_o  (rise_pulse_o[i]),
            .stretch_out_o (stretch_out_o[i]),
            .sticky_o      (sticky_o[i]),
            .evt_cnt_o     (evt_cnt_o[i*CNT_W +: CNT_W])
        );
    end

    assign busy_o = |stretch_out_o;

endmodule

`default_nettype wire
